// File: rtl/jtpang_dmaack_if.sv
// Bus grouping for the object DMA handshake and the shared VRAM path.
// The slave modport is the jtpang_dmaack side; the master modport is the
// surroundings (object DMA, Z80 core, VRAM).
interface jtpang_dmaack_if;
  logic        busrq;
  logic        busak_n;
  logic        mreq_n;
  logic        iorq_n;
  logic [11:0] cpu_addr;
  logic        cpu_vram_cs;
  logic        cpu_wr_n;
  logic [8:0]  dma_addr;
  logic [11:0] bus_addr;
  logic        bus_vram_cs;
  logic        bus_wr_n;

  modport slave (
    input  busrq, mreq_n, iorq_n, cpu_addr, cpu_vram_cs, cpu_wr_n, dma_addr,
    output busak_n, bus_addr, bus_vram_cs, bus_wr_n
  );

  modport master (
    output busrq, mreq_n, iorq_n, cpu_addr, cpu_vram_cs, cpu_wr_n, dma_addr,
    input  busak_n, bus_addr, bus_vram_cs, bus_wr_n
  );
endinterface

// File: rtl/jtpang_dmaack.sv
// CPU-side responder for the object DMA bus request.
// Waits for the Z80 bus to go idle, grants it (busak_n low), freezes the CPU
// clock enable and steers the VRAM address/strobes to the DMA address.
// Optional watchdog: define JTPANG_DMA_WDOG_EN to force a release after
// WDOG_MAX cpu_cen pulses in GRANT and raise the sticky dma_tout flag.
module jtpang_dmaack #(
  parameter logic [11:0] DMA_BASE = 12'h000,
  parameter logic [15:0] WDOG_MAX = 16'd8192
) (
  input  logic rst,
  input  logic clk,
  input  logic cpu_cen,
  output logic cen_gated,
  output logic dma_tout,
  jtpang_dmaack_if.slave dbus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GRANT,
    ST_REL
  } state_t;

  state_t state_q, state_d;
  logic   busak_n_q, busak_n_d;
  logic   granted;

`ifdef JTPANG_DMA_WDOG_EN
  localparam logic [15:0] WDOG_LAST = WDOG_MAX - 16'd1;
  logic [15:0] cnt_q, cnt_d;
  logic        tout_q, tout_d;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_MAX;
`endif

  // Next state; everything holds unless cpu_cen is high
  always_comb begin
    state_d = state_q;
`ifdef JTPANG_DMA_WDOG_EN
    cnt_d  = cnt_q;
    tout_d = tout_q;
`endif
    if (cpu_cen) begin
      case (state_q)
        ST_IDLE: if (dbus.busrq) state_d = ST_WAIT;
        ST_WAIT: begin
          if (!dbus.busrq) begin
            state_d = ST_IDLE;
          end else if (dbus.mreq_n && dbus.iorq_n) begin
            state_d = ST_GRANT;
`ifdef JTPANG_DMA_WDOG_EN
            cnt_d = '0;
`endif
          end
        end
        ST_GRANT: begin
          if (!dbus.busrq) begin
            state_d = ST_REL;
`ifdef JTPANG_DMA_WDOG_EN
          end else if (cnt_q == WDOG_LAST) begin
            state_d = ST_REL;
            tout_d  = 1'b1;
`endif
          end
`ifdef JTPANG_DMA_WDOG_EN
          cnt_d = cnt_q + 16'd1;
`endif
        end
        ST_REL:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // busak_n is registered alongside the state so it falls on the GRANT entry edge
    busak_n_d = (state_d != ST_GRANT);
  end

  // State and acknowledge registers; reset acts on any clk edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busak_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      busak_n_q <= busak_n_d;
    end
  end

`ifdef JTPANG_DMA_WDOG_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end

  assign dma_tout = tout_q;
`else
  assign dma_tout = 1'b0;
`endif

  assign granted      = (state_q == ST_GRANT);
  assign dbus.busak_n = busak_n_q;

  // CPU clock gating and VRAM path steering from the registered state
  always_comb begin
    cen_gated        = cpu_cen & ~((state_q == ST_GRANT) || (state_q == ST_REL));
    dbus.bus_addr    = dbus.cpu_addr;
    dbus.bus_vram_cs = dbus.cpu_vram_cs;
    dbus.bus_wr_n    = dbus.cpu_wr_n;
    if (granted) begin
      dbus.bus_addr    = DMA_BASE | {3'b000, dbus.dma_addr};
      dbus.bus_vram_cs = 1'b1;
      dbus.bus_wr_n    = 1'b1;
    end
  end

endmodule

// File: tb/tb_jtpang_dmaack.sv
// Self-checking bench for jtpang_dmaack: a per-cen vector table run through an
// expectation queue, followed by reset-in-grant and long-grant sequences.
module tb_jtpang_dmaack;

  localparam logic [11:0] BASE     = 12'h800;
  localparam logic [11:0] CPU_A    = 12'hA5C;
  localparam logic [8:0]  DMA_A    = 9'h1F3;
  localparam logic [11:0] DMA_BUS  = 12'h9F3;

  logic clk;
  logic rst;
  logic cpu_cen;
  logic cen_gated;
  logic dma_tout;

  jtpang_dmaack_if bus ();

  jtpang_dmaack #(
    .DMA_BASE (BASE),
    .WDOG_MAX (16'd16)
  ) dut (
    .rst       (rst),
    .clk       (clk),
    .cpu_cen   (cpu_cen),
    .cen_gated (cen_gated),
    .dma_tout  (dma_tout),
    .dbus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busrq, mreq_n, iorq_n} stimulus, {busak_n, cen_gated, dma_sel} expected
  typedef struct packed {
    logic busrq;
    logic mreq_n;
    logic iorq_n;
    logic e_busak_n;
    logic e_cen;
    logic e_dma;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];
  vec_t expq [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Raise cpu_cen for the coming edge and settle before sampling
  task automatic pre_cen();
    cpu_cen = 1'b1;
    #2;
  endtask

  // Take the cen edge, then two idle clocks with cpu_cen low
  task automatic post_cen();
    @(posedge clk);
    #1 cpu_cen = 1'b0;
    #1 chk("offcen cen_gated", {31'd0, cen_gated}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_outputs(input string tag, input logic e_busak_n,
                             input logic e_cen, input logic e_dma);
    chk({tag, " busak_n"},     {31'd0, bus.busak_n},     {31'd0, e_busak_n});
    chk({tag, " cen_gated"},   {31'd0, cen_gated},       {31'd0, e_cen});
    chk({tag, " bus_addr"},    {20'd0, bus.bus_addr},    {20'd0, (e_dma ? DMA_BUS : CPU_A)});
    chk({tag, " bus_vram_cs"}, {31'd0, bus.bus_vram_cs}, {31'd0, e_dma});
    chk({tag, " bus_wr_n"},    {31'd0, bus.bus_wr_n},    {31'd0, e_dma});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int cnt;
    int k;
    vec_t ev;

    // Bus idle, grant, release
    tbl[0]  = 6'b011_110;
    tbl[1]  = 6'b111_110;
    tbl[2]  = 6'b111_110;
    tbl[3]  = 6'b111_001;
    tbl[4]  = 6'b111_001;
    tbl[5]  = 6'b011_001;
    tbl[6]  = 6'b011_100;
    tbl[7]  = 6'b011_110;
    // Bus busy for several cens, then grant; request re-raised in REL
    tbl[8]  = 6'b101_110;
    tbl[9]  = 6'b101_110;
    tbl[10] = 6'b101_110;
    tbl[11] = 6'b101_110;
    tbl[12] = 6'b110_110;
    tbl[13] = 6'b111_110;
    tbl[14] = 6'b011_001;
    tbl[15] = 6'b111_100;
    tbl[16] = 6'b111_110;
    // Request dropped while waiting
    tbl[17] = 6'b011_110;
    tbl[18] = 6'b011_110;
    tbl[19] = 6'b101_110;
    tbl[20] = 6'b001_110;
    // Fresh request after the aborted one
    tbl[21] = 6'b111_110;
    tbl[22] = 6'b111_110;
    tbl[23] = 6'b011_001;
    tbl[24] = 6'b011_100;
    tbl[25] = 6'b011_110;

    rst             = 1'b1;
    cpu_cen         = 1'b0;
    bus.busrq       = 1'b0;
    bus.mreq_n      = 1'b1;
    bus.iorq_n      = 1'b1;
    bus.cpu_addr    = CPU_A;
    bus.cpu_vram_cs = 1'b0;
    bus.cpu_wr_n    = 1'b0;
    bus.dma_addr    = DMA_A;

    repeat (3) @(posedge clk);
    #1;
    chk("reset busak_n",  {31'd0, bus.busak_n}, 32'd1);
    chk("reset dma_tout", {31'd0, dma_tout},    32'd0);
    chk("reset cen_gated lo", {31'd0, cen_gated}, 32'd0);
    cpu_cen = 1'b1;
    #1 chk("reset cen_gated hi", {31'd0, cen_gated}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    cpu_cen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < NV; i++) begin
      bus.busrq  = tbl[i].busrq;
      bus.mreq_n = tbl[i].mreq_n;
      bus.iorq_n = tbl[i].iorq_n;
      expq.push_back(tbl[i]);
      pre_cen();
      ev = expq.pop_front();
      chk_outputs($sformatf("v%0d", i), ev.e_busak_n, ev.e_cen, ev.e_dma);
      chk($sformatf("v%0d dma_tout", i), {31'd0, dma_tout}, 32'd0);
      post_cen();
    end

    // Reset while granted, busrq still high across reset release
    bus.busrq = 1'b1;
    pre_cen();
    post_cen();
    pre_cen();
    post_cen();
    pre_cen();
    chk_outputs("pre-rst grant", 1'b0, 1'b0, 1'b1);
    post_cen();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cpu_cen = 1'b1;
    #1;
    chk_outputs("post-rst", 1'b1, 1'b1, 1'b0);
    chk("post-rst dma_tout", {31'd0, dma_tout}, 32'd0);
    post_cen();
    pre_cen();
    chk("rst-release 1st cen busak_n", {31'd0, bus.busak_n}, 32'd1);
    post_cen();
    pre_cen();
    chk_outputs("rst-release regrant", 1'b0, 1'b0, 1'b1);
    post_cen();

    // Long grant with busrq held: count cen periods spent granted
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      pre_cen();
      if (bus.busak_n) break;
      cnt++;
      post_cen();
    end
`ifdef JTPANG_DMA_WDOG_EN
    chk("wdog cens in grant", cnt, 16);
    chk("wdog dma_tout", {31'd0, dma_tout}, 32'd1);
    chk("wdog rel cen_gated", {31'd0, cen_gated}, 32'd0);
    post_cen();
    k = 0;
    for (int i = 0; i < 10; i++) begin
      pre_cen();
      k++;
      if (!bus.busak_n) break;
      post_cen();
    end
    chk("wdog cens to regrant", k, 3);
    chk("wdog dma_tout sticky", {31'd0, dma_tout}, 32'd1);
    post_cen();
`else
    k = 0;
    chk("hold cens in grant", cnt, 41);
    chk("hold busak_n", {31'd0, bus.busak_n}, 32'd0);
    chk("hold dma_tout", {31'd0, dma_tout}, 32'd0);
    post_cen();
`endif

    // Release and confirm the CPU resumes two cens later
    bus.busrq = 1'b0;
    pre_cen();
    post_cen();
    pre_cen();
    chk("final rel busak_n", {31'd0, bus.busak_n}, 32'd1);
    chk("final rel cen_gated", {31'd0, cen_gated}, 32'd0);
    post_cen();
    pre_cen();
    chk_outputs("final idle", 1'b1, 1'b1, 1'b0);
    post_cen();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtpang_dmaack.md
Name: jtpang_dmaack

Overview:
- CPU-side responder for the object DMA bus request.
- Watches busrq from the object engine, waits for the Z80 bus to go idle, grants the bus with busak_n low, freezes the CPU clock enable, and steers the shared VRAM address/strobe path to the DMA address while granted.
- Sits in the Pang main board between the CPU clock-enable generator, the Z80 core and the video block.

Parameters:
- DMA_BASE, 12'h000, base OR-ed onto the 9-bit DMA address to form the VRAM address during grant.
- WDOG_MAX, 16'd8192, cpu_cen pulses allowed in GRANT before forced release (used only with the optional feature).

Ports:
- rst  input  1  synchronous reset, active-high
- clk  input  1  system clock
- cpu_cen  input  1  ungated CPU clock enable
- cen_gated  output  1  CPU clock enable sent to the Z80 core
- busrq  input  1  bus request from the object DMA, active-high
- busak_n  output  1  bus acknowledge to the object DMA, active-low
- mreq_n  input  1  CPU memory request
- iorq_n  input  1  CPU I/O request
- cpu_addr  input  12  CPU address
- cpu_vram_cs  input  1  CPU VRAM select
- cpu_wr_n  input  1  CPU write strobe
- dma_addr  input  9  DMA read address
- bus_addr  output  12  address to VRAM
- bus_vram_cs  output  1  VRAM select to VRAM
- bus_wr_n  output  1  write strobe to VRAM
- dma_tout  output  1  sticky watchdog timeout flag

Behaviour:
- All state advances only on clk edges where cpu_cen=1, except reset, which acts on any clk edge.
- Reset values:
  - state=IDLE, busak_n=1, dma_tout=0, watchdog counter=0.
  - cen_gated follows cpu_cen.
- States and transitions:
  - IDLE: on busrq=1, go to WAIT.
  - WAIT: CPU keeps running.
    - Go to GRANT on the first cpu_cen where mreq_n=1 and iorq_n=1.
    - If busrq drops in WAIT, return to IDLE with no grant.
  - GRANT:
    - busak_n=0, registered, so it goes low on the same cen edge as entry.
    - cen_gated forced to 0 from the next clk after entry.
    - On busrq=0 go to REL.
  - REL: busak_n=1 on entry; cen_gated stays 0 for this one cpu_cen period; then go to IDLE and ungate.
- Latency:
  - busrq to busak_n low: minimum 2 cpu_cen pulses (IDLE→WAIT→GRANT).
  - busrq low to CPU resume: 2 cpu_cen pulses.
- Gating: cen_gated = cpu_cen & ~(state==GRANT || state==REL).
- Bus mux, combinational from the registered state:
  - In GRANT: bus_addr = DMA_BASE | {3'b0, dma_addr}, bus_vram_cs=1, bus_wr_n=1.
  - Otherwise: CPU signals pass through unchanged.
- busrq is asserted again in REL: the request is ignored until IDLE, then processed normally. No back-to-back grant without a resume period.
- Reset in GRANT: busak_n returns to 1 and the CPU is ungated on the same edge.
- busrq already high at reset release: the sequence starts at the first cpu_cen.

Optional Feature:
- Macro: JTPANG_DMA_WDOG_EN.
- With the macro:
  - A 16-bit counter clears on GRANT entry and increments per cpu_cen in GRANT.
  - When the count reaches WDOG_MAX-1 while busrq is still 1: go to REL, set dma_tout=1 (sticky until rst), and return to IDLE.
  - The still-high busrq is then re-served as a new request.
- Without the macro: no counter, dma_tout tied 0, GRANT lasts as long as busrq.

Test Plan:
- Bus idle, cpu_cen every 3rd clk, busrq rises → busak_n low after 2 cpu_cen; cen_gated 0 until release; bus_addr=dma_addr; bus_wr_n=1.
- Bus busy, mreq_n=0 for 4 cen after busrq → grant on the first cen with mreq_n=1; no cen_gated pulse lost before then.
- busrq 1→0 while in WAIT → busak_n never low, CPU never gated, back to IDLE.
- Release: busrq drops in GRANT → busak_n high on the next cen; cen_gated resumes one cen later; bus_addr shows cpu_addr again.
- rst pulsed mid-GRANT → busak_n=1 and cen_gated=cpu_cen on the following clk; dma_tout=0.
- With JTPANG_DMA_WDOG_EN, WDOG_MAX=16, busrq held high → release after 16 cen in GRANT, dma_tout=1, new grant 2 cen later.
